// File: rtl/uart2ahb_pkg.sv
// Shared constants for the uart2ahb bridge: baud generator widths and default divisors.
// Divisor defaults assume a 50 MHz project clock with 16x oversampling.
package uart2ahb_pkg;

    localparam int BAUD_W  = 18;
    localparam int BAUD_OS = 16;
    localparam int CLK_HZ  = 50_000_000;

    // round(CLK_HZ / (baud * BAUD_OS))
    localparam logic [BAUD_W-1:0] DIV_115200 = 18'd27;
    localparam logic [BAUD_W-1:0] DIV_9600   = 18'd326;

    function automatic int os_cnt_w(input int os);
        return $clog2(os);
    endfunction

endpackage

// File: rtl/borrow_cmp.sv
// W-bit ripple subtractor reduced to its borrow chain; ge is high when a >= b (unsigned).
module borrow_cmp #(
    parameter int W = 18
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ge
);

    // Each stage keeps its own borrow nets so the chain is not one self-referencing vector.
    for (genvar gi = 0; gi < W; gi++) begin : g_stage
        logic bin;
        logic bout;
        if (gi == 0) begin : g_first
            assign bin = 1'b0;
        end else begin : g_next
            assign bin = g_stage[gi-1].bout;
        end
        assign bout = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & bin);
    end

    assign ge = ~g_stage[W-1].bout;

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: prescaler, oversample counter and shadowed divisor.
// Emits registered os/mid/bit ticks for the UART RX/TX samplers.
module baud_tick_gen
    import uart2ahb_pkg::*;
#(
    parameter int           W         = BAUD_W,
    parameter int           OS        = BAUD_OS,
    parameter logic [W-1:0] DIV_RESET = W'(DIV_115200)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         div_wr,
    input  logic [W-1:0] div_in,
    output logic         os_tick,
    output logic         mid_tick,
    output logic         bit_tick,
    output logic [W-1:0] cnt,
    output logic [W-1:0] div_cur,
    output logic         div_pend
);

    localparam int             OSW       = os_cnt_w(OS);
    localparam logic [W-1:0]   ONE       = W'(1);
    localparam logic [W-1:0]   DIV_RST_S = (DIV_RESET == '0) ? ONE : DIV_RESET;
    localparam logic [OSW-1:0] OS_ONE    = OSW'(1);
    localparam logic [OSW-1:0] OS_MID    = OSW'(OS / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST   = OSW'(OS - 1);

    logic [W-1:0]   cnt_reg, cnt_next;
    logic [W-1:0]   div_cur_reg, div_cur_next;
    logic [W-1:0]   shadow_reg, shadow_next;
    logic [OSW-1:0] os_cnt_reg, os_cnt_next;
    logic           pend_reg, pend_next;
    logic           os_tick_reg, os_tick_next;
    logic           mid_tick_reg, mid_tick_next;
    logic           bit_tick_reg, bit_tick_next;

    logic [W-1:0]   div_lim;
    logic [W-1:0]   div_in_s;
    logic           term;
    logic           apply;

    // div_cur is never 0, so div_cur-1 cannot underflow.
    assign div_lim  = div_cur_reg - ONE;
    assign div_in_s = (div_in == '0) ? ONE : div_in;

    borrow_cmp #(.W(W)) u_term_cmp (
        .a  (cnt_reg),
        .b  (div_lim),
        .ge (term)
    );

    // A pending divisor is swapped in only where the prescale phase is safe to disturb.
    assign apply = pend_reg & ((term & en) | ~en | clr);

    always_comb begin
        cnt_next      = cnt_reg;
        os_cnt_next   = os_cnt_reg;
        div_cur_next  = div_cur_reg;
        shadow_next   = shadow_reg;
        pend_next     = pend_reg;
        os_tick_next  = 1'b0;
        mid_tick_next = 1'b0;
        bit_tick_next = 1'b0;

        if (clr) begin
            cnt_next    = '0;
            os_cnt_next = '0;
        end else if (en) begin
            if (term) begin
                cnt_next      = '0;
                os_cnt_next   = os_cnt_reg + OS_ONE;
                os_tick_next  = 1'b1;
                mid_tick_next = (os_cnt_reg == OS_MID);
                bit_tick_next = (os_cnt_reg == OS_LAST);
            end else begin
                cnt_next = cnt_reg + ONE;
            end
        end

        if (apply) begin
            div_cur_next = shadow_reg;
            pend_next    = 1'b0;
        end
        // A write on the apply edge lands in the shadow and stays pending.
        if (div_wr) begin
            shadow_next = div_in_s;
            pend_next   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            os_cnt_reg   <= '0;
            div_cur_reg  <= DIV_RST_S;
            shadow_reg   <= DIV_RST_S;
            pend_reg     <= 1'b0;
            os_tick_reg  <= 1'b0;
            mid_tick_reg <= 1'b0;
            bit_tick_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            os_cnt_reg   <= os_cnt_next;
            div_cur_reg  <= div_cur_next;
            shadow_reg   <= shadow_next;
            pend_reg     <= pend_next;
            os_tick_reg  <= os_tick_next;
            mid_tick_reg <= mid_tick_next;
            bit_tick_reg <= bit_tick_next;
        end
    end

    assign os_tick  = os_tick_reg;
    assign mid_tick = mid_tick_reg;
    assign bit_tick = bit_tick_reg;
    assign cnt      = cnt_reg;
    assign div_cur  = div_cur_reg;
    assign div_pend = pend_reg;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed and random stimulus for baud_tick_gen, checked cycle by cycle against a behavioural model.
module tb_baud_tick_gen;

    localparam int W    = 18;
    localparam int OS   = 16;
    localparam int DIVR = 27;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         clr;
    logic         div_wr;
    logic [W-1:0] div_in;
    logic         os_tick;
    logic         mid_tick;
    logic         bit_tick;
    logic [W-1:0] cnt;
    logic [W-1:0] div_cur;
    logic         div_pend;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: prescale count, oversample slot, divisors, expected ticks.
    int m_cnt, m_os, m_div, m_shadow;
    bit m_pend, m_ost, m_mid, m_bit;

    baud_tick_gen #(.W(W), .OS(OS), .DIV_RESET(18'd27)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick),
        .cnt      (cnt),
        .div_cur  (div_cur),
        .div_pend (div_pend)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_os = 0; m_div = DIVR; m_shadow = DIVR;
        m_pend = 0; m_ost = 0; m_mid = 0; m_bit = 0;
    endtask

    task automatic model_step(input bit e, input bit c, input bit w, input int d);
        bit wraps;
        bit take;
        wraps = (m_cnt >= m_div - 1);
        take  = m_pend && (!e || c || wraps);
        m_ost = 0; m_mid = 0; m_bit = 0;
        if (c) begin
            m_cnt = 0;
            m_os  = 0;
        end else if (e) begin
            if (wraps) begin
                m_ost = 1;
                m_mid = (m_os == OS / 2 - 1);
                m_bit = (m_os == OS - 1);
                m_os  = (m_os + 1) % OS;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (take) begin
            m_div  = m_shadow;
            m_pend = 0;
        end
        if (w) begin
            m_shadow = (d == 0) ? 1 : d;
            m_pend   = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt"},      cnt,      m_cnt);
        chk({tag, ".div_cur"},  div_cur,  m_div);
        chk({tag, ".div_pend"}, div_pend, m_pend);
        chk({tag, ".os_tick"},  os_tick,  m_ost);
        chk({tag, ".mid_tick"}, mid_tick, m_mid);
        chk({tag, ".bit_tick"}, bit_tick, m_bit);
    endtask

    task automatic cyc(input bit e, input bit c, input bit w, input int d, input string tag);
        @(negedge clk);
        en = e; clr = c; div_wr = w; div_in = W'(d);
        @(posedge clk);
        model_step(e, c, w, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        int first_os, first_mid, first_bit, n_os, gap;

        rst = 1'b1; en = 1'b0; clr = 1'b0; div_wr = 1'b0; div_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Default divisor: os every 27, mid at 8th wrap, bit at 16th wrap.
        first_os = -1; first_mid = -1; first_bit = -1;
        for (int i = 1; i <= 440; i++) begin
            cyc(1, 0, 0, 0, "run27");
            if (os_tick  && first_os  < 0) first_os  = i;
            if (mid_tick && first_mid < 0) first_mid = i;
            if (bit_tick && first_bit < 0) first_bit = i;
        end
        chk("first_os_tick",  first_os,  27);
        chk("first_mid_tick", first_mid, 216);
        chk("first_bit_tick", first_bit, 432);

        // Shadow write mid-count waits for the wrap.
        cyc(1, 0, 0, 0, "pre_wr");
        cyc(1, 0, 0, 0, "pre_wr");
        chk("cnt_at_wr", cnt, 10);
        cyc(1, 0, 1, 5, "wr5");
        chk("wr5_pend", div_pend, 1);
        chk("wr5_div_held", div_cur, 27);
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1, 0, 0, 0, "to_wrap");
            if (os_tick) begin gap = i; break; end
        end
        chk("wrap_after_wr", gap, 16);
        chk("div_applied5", div_cur, 5);
        chk("pend_cleared5", div_pend, 0);
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1, 0, 0, 0, "period5");
            if (os_tick) begin gap = i; break; end
        end
        chk("os_period5", gap, 5);

        // Divisor shrunk below a held count forces an immediate wrap.
        cyc(0, 0, 1, 30, "wr30");
        cyc(0, 0, 0, 0, "apply30");
        cyc(1, 1, 0, 0, "clr30");
        repeat (20) cyc(1, 0, 0, 0, "count20");
        chk("cnt20", cnt, 20);
        cyc(0, 0, 1, 3, "wr3");
        chk("wr3_pend", div_pend, 1);
        cyc(0, 0, 0, 0, "apply3");
        chk("div3_applied", div_cur, 3);
        chk("cnt20_held", cnt, 20);
        cyc(1, 0, 0, 0, "force_wrap");
        chk("forced_os_tick", os_tick, 1);
        chk("forced_cnt0", cnt, 0);

        // Zero divisor sanitised to 1.
        cyc(0, 0, 1, 0, "wr0");
        cyc(0, 0, 0, 0, "apply0");
        chk("div0_as_1", div_cur, 1);
        cyc(1, 1, 0, 0, "clr1");
        n_os = 0; first_bit = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1, 0, 0, 0, "div1");
            if (os_tick) n_os++;
            if (bit_tick && first_bit < 0) first_bit = i;
        end
        chk("div1_os_every_cycle", n_os, 40);
        chk("div1_first_bit", first_bit, 16);

        // clr mid-frame restarts the oversample slot count.
        cyc(1, 1, 0, 0, "clr_a");
        repeat (7) cyc(1, 0, 0, 0, "to_os7");
        cyc(1, 1, 0, 0, "clr_os7");
        chk("clr_cnt0", cnt, 0);
        chk("clr_no_tick", os_tick, 0);
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1, 0, 0, 0, "after_clr");
            if (bit_tick) begin gap = i; break; end
        end
        chk("bit_after_clr", gap, 16);

        // Random mix of enable, clear and divisor writes.
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 14) == 0, int'($urandom_range(0, 6)), "rand");
        end

        // Async reset mid-count discards a pending shadow.
        cyc(0, 0, 1, 27, "wr27");
        cyc(0, 0, 0, 0, "apply27");
        cyc(1, 1, 0, 0, "clr27");
        repeat (12) cyc(1, 0, 0, 0, "count12");
        cyc(1, 0, 1, 9, "wr9");
        chk("pre_rst_cnt", cnt, 13);
        chk("pre_rst_pend", div_pend, 1);
        #2;
        rst = 1'b1; en = 1'b0; clr = 1'b0; div_wr = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 0, "post_rst_idle");
        chk("post_rst_div", div_cur, 27);
        chk("post_rst_pend", div_pend, 0);
        first_os = -1;
        for (int i = 1; i <= 30; i++) begin
            cyc(1, 0, 0, 0, "post_rst");
            if (os_tick && first_os < 0) first_os = i;
        end
        chk("post_rst_first_os", first_os, 27);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised, programmable baud-rate tick generator for the uart2ahb bridge.
- Replaces the fixed 18-bit subtract-and-borrow compare plus external counter with one self-contained block.
- Contains the divisor counter, the compare, an oversample counter and a shadowed divisor register.
- Produces an oversample tick for the UART RX/TX samplers, a mid-bit tick and a bit tick.

Parameters:
- W, 18, width of the divisor and of the prescale counter.
- OS, 16, oversample ratio. Must be a power of two, at least 4.
- DIV_RESET, 18'd27, divisor value loaded at reset (prescale period in clk cycles).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable. When low, counters hold and no ticks are produced.
- clr  in  1  synchronous clear of both counters. Divisor register is not affected.
- div_wr  in  1  one-cycle strobe that writes div_in into the shadow register.
- div_in  in  W  new divisor value.
- os_tick  out  1  one-cycle pulse once every div_cur cycles while enabled.
- mid_tick  out  1  one-cycle pulse on the os_tick that ends oversample slot OS/2-1.
- bit_tick  out  1  one-cycle pulse on the os_tick that ends oversample slot OS-1.
- cnt  out  W  current prescale count.
- div_cur  out  W  divisor currently in effect.
- div_pend  out  1  high while a shadow divisor is waiting to be applied.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, os_cnt=0, div_cur=DIV_RESET, shadow=DIV_RESET, div_pend=0.
  - All tick outputs are 0.
- Divisor sanitising: a value of 0 is stored as 1. Divisor 1 gives os_tick on every enabled cycle.
- Terminal compare:
  - term = (cnt >= div_cur-1), computed as the borrow-out of cnt - (div_cur-1).
  - This is a W-bit unsigned compare with no overflow path.
  - Using >= rather than == means a divisor reduced below the current cnt forces a wrap on the next enabled cycle instead of a 2^W-cycle runaway.
- Enabled cycle (en=1, clr=0):
  - If term: cnt←0, os_tick=1, os_cnt←(os_cnt+1) mod OS.
  - Otherwise: cnt←cnt+1.
- Ticks:
  - os_tick, mid_tick and bit_tick are registered: the pulse appears in the cycle after the wrapping edge and lasts exactly one cycle.
  - mid_tick = os_tick & (os_cnt was OS/2-1 before increment).
  - bit_tick = os_tick & (os_cnt was OS-1 before increment).
- Disabled (en=0): cnt and os_cnt hold, all ticks are 0.
- clr:
  - cnt←0, os_cnt←0, ticks are 0 in the following cycle.
  - clr has priority over en.
  - A div_wr in the same cycle is still captured.
- Shadow divisor:
  - div_wr captures the sanitised div_in into shadow and sets div_pend.
  - Apply point: the pending shadow is applied (div_cur←shadow, div_pend←0) on the first edge where any of these holds: the wrap (term & en), en=0, or clr.
  - Back-to-back writes: the last write before the apply point wins.
  - div_wr coincident with the apply point: the new value goes to shadow and div_pend stays 1. The previous shadow value is applied on that edge.
- Width: os_cnt is log2(OS) bits and wraps naturally. No arithmetic result exceeds W bits.
- Reset mid-operation: everything returns to reset values immediately (async). The first tick after release comes DIV_RESET enabled cycles later.

Decomposition:
- Package uart2ahb_pkg holds:
  - BAUD_W (18) and BAUD_OS (16) constants;
  - default divisor constants for 115200 and 9600 at the project clock;
  - the os_cnt width function (clog2).
- Sub-module borrow_cmp:
  - parametrised W-bit ripple subtract;
  - outputs ge = ~borrow(A-B);
  - this is the generalised successor of the fixed 18-bit subtractor.
- Instantiate borrow_cmp once for the terminal compare.

Test Plan:
- Reset, then en=1 with DIV_RESET=27 → first os_tick 27 cycles after release, then every 27 cycles. bit_tick every 432 cycles, mid_tick 216 cycles before each bit_tick.
- div_wr with div_in=5 while cnt=10 and div_cur=27 → div_pend=1, div_cur stays 27 until the wrap. After the wrap, os_tick period is 5 and div_pend=0.
- en=0, then div_wr with div_in=3 → applied on the next edge (div_cur=3). With cnt=20 held and en raised, term is true, so os_tick follows the first enabled edge and cnt=0.
- div_in=0 → div_cur=1 and os_tick on every enabled cycle. bit_tick every 16 cycles.
- clr asserted with os_cnt=7 and en=1 → cnt=0, os_cnt=0, no tick that cycle. The next bit_tick is 16 os_ticks later.
- rst pulsed mid-count (cnt=13, div_pend=1) → outputs return to reset values asynchronously, the pending shadow is discarded, and div_cur=27.
